receive: RTL
============

// Module: receive
// PURPOSE
//  Downstream partner of the instruction transmitter. Requests a burst of
//  instructions (syn), captures each acked word into a local instruction RAM,
//  and flags completion/overflow/timeout. A registered read port then serves
//  the fetch stage; r_o_done releases the CPU from load mode.
// PARAMETERS
//  IWIDTH   `IWIDTH (32)  instruction width, from the shared defines header
//  DEPTH    64            instruction RAM depth in words
//  AWIDTH   6             address width, equal to log2(DEPTH)
//  TIMEOUT  16            max cycles in LOAD with no ack before the load aborts
// PORTS
//  r_clk      in   1       clock, rising edge
//  r_rst      in   1       asynchronous, active-low reset
//  r_i_start  in   1       pulse: begin a new load (accepted in IDLE/DONE only)
//  r_o_syn    out  1       request to transmitter, high while in LOAD
//  r_i_instr  in   IWIDTH  instruction word from transmitter
//  r_i_ack    in   1       r_i_instr is valid this cycle
//  r_i_last   in   1       qualifies the final word (valid only with r_i_ack)
//  r_o_done   out  1       load finished; held until next accepted start
//  r_o_err    out  1       overflow or timeout occurred; valid when r_o_done
//  r_o_count  out  AWIDTH+1  number of words stored by the last load
//  r_i_raddr  in   AWIDTH  fetch read address
//  r_o_instr  out  IWIDTH  mem[r_i_raddr], one-cycle registered latency
// BEHAVIOUR
//  Reset (r_rst=0, async): state=IDLE. r_o_syn, r_o_done, r_o_err, r_o_count
//   and r_o_instr are cleared to 0. The write pointer and timeout counter are
//   cleared. RAM contents are not reset.
//  FSM states are IDLE, LOAD and DONE.
//   IDLE: r_i_start moves to LOAD and clears count, err and done.
//   LOAD: r_o_syn=1 (registered; rises the cycle after start).
//    - ack=1: write mem[wptr]=r_i_instr, then increment wptr/count and
//      clear the timeout counter.
//    - ack=1 and last=1: store the word, go to DONE, done=1, err=0.
//    - ack=1, last=0 and wptr==DEPTH-1: store the word (count=DEPTH),
//      go to DONE with err=1. The RAM never wraps.
//    - ack=0: increment the timeout counter. When it reaches TIMEOUT,
//      go to DONE with err=1; count keeps the words received so far.
//    - r_i_start is ignored in LOAD.
//   DONE: syn=0 and done=1. Any ack or last is ignored and nothing is written.
//    r_i_start restarts the load (same as from IDLE).
//  ack in IDLE or DONE: ignored. last without ack: ignored.
//  r_o_syn falls the cycle after the terminating word. That word is the
//   last one accepted; an ack in the following cycle is dropped.
//  Read port: r_o_instr <= mem[r_i_raddr] on every clock, in every state.
//   When a read and a write target the same address in the same cycle, the
//   read returns the old data (read-before-write).
//  Reset mid-LOAD aborts immediately: syn drops asynchronously and count=0.
// STRUCTURE
//  Shared defines header: `IWIDTH. State encodings are localparams in this file.
//  One sub-module, instr_ram: 1 write port, 1 registered read port,
//   DEPTH x IWIDTH, with read-before-write on an address collision.
//  The FSM, write pointer, count and timeout counter stay in this module.
// TESTING
//  1 Reset for 2 cycles -> syn, done, err, count and instr are all 0.
//  2 Start, then 6 acked words 0x20080001..06 with last on the 6th ->
//    syn falls next cycle, done=1, err=0, count=6.
//    Reading addr 0..5 returns the words, each one cycle after its address.
//  3 Start, then 64 acked words with last never set -> count=64, err=1,
//    done=1. A 65th ack is dropped and mem[0] is unchanged.
//  4 Start, 3 acked words, then ack=0 for 16 cycles -> done=1, err=1, count=3.
//  5 Start, then reset asserted after 2 words -> all outputs 0 at once.
//    A new start after reset reloads from addr 0.
//  6 Ack/last pulses in IDLE and DONE, plus start during LOAD -> no writes,
//    count unchanged, state unchanged.

Source files
------------

// File: rtl/receive_pkg.sv
// Shared widths, sizes and FSM encoding for the instruction receiver.
`ifndef IWIDTH
`define IWIDTH 32
`endif

package receive_pkg;
  localparam int IWIDTH  = `IWIDTH;
  localparam int DEPTH   = 64;
  localparam int AWIDTH  = 6;
  localparam int CWIDTH  = AWIDTH + 1;
  localparam int TIMEOUT = 16;
  localparam int TWIDTH  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/receive_instr_ram.sv
// Single write port, registered read port instruction store; a same-address
// read and write in one cycle returns the previous contents.
module instr_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; the array keeps its contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/receive.sv
// Instruction receiver: requests a burst, stores acked words, reports
// completion, overflow or timeout, and serves fetch reads.
module receive
  import receive_pkg::*;
(
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_i_start,
  output logic              r_o_syn,
  input  logic [IWIDTH-1:0] r_i_instr,
  input  logic              r_i_ack,
  input  logic              r_i_last,
  output logic              r_o_done,
  output logic              r_o_err,
  output logic [CWIDTH-1:0] r_o_count,
  input  logic [AWIDTH-1:0] r_i_raddr,
  output logic [IWIDTH-1:0] r_o_instr
);
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [TWIDTH-1:0] tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              syn_q, syn_d;
  logic              we;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    done_d  = done_q;
    we      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (r_i_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          done_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (r_i_ack) begin
          we     = 1'b1;
          wptr_d = wptr_q + AWIDTH'(1);
          cnt_d  = cnt_q + CWIDTH'(1);
          tmo_d  = '0;
          if (r_i_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
          end else if (wptr_q == AWIDTH'(DEPTH - 1)) begin
            // RAM full without a last marker: stop rather than wrap.
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TWIDTH'(1);
          if (tmo_q == TWIDTH'(TIMEOUT - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    syn_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      syn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      done_q  <= done_d;
      syn_q   <= syn_d;
    end
  end

  instr_ram #(
    .DATA_W(IWIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(AWIDTH)
  ) u_ram (
    .clk_i  (r_clk),
    .rst_ni (r_rst),
    .we_i   (we),
    .waddr_i(wptr_q),
    .wdata_i(r_i_instr),
    .raddr_i(r_i_raddr),
    .rdata_o(r_o_instr)
  );

  assign r_o_syn   = syn_q;
  assign r_o_done  = done_q;
  assign r_o_err   = err_q;
  assign r_o_count = cnt_q;
endmodule
